asmi_prog_ctrl: RTL and testbench

//  Sequences remote flash (ASMI) update traffic from the downstream OpenHPSDR unpacker into a flash engine.

---
 rtl/asmi_prog_ctrl_if.sv | 38 +++
 rtl/asmi_prog_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_asmi_prog_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/asmi_prog_ctrl_if.sv
// Purpose: bundles the downstream unpacker signals (dseth*/asmi_*) and the
//          flash engine signals (fl_*) used by asmi_prog_ctrl.
// Modports:
//   slave  - the controller's view: it receives unpacker traffic, drives
//            flash commands and reports progress.
//   master - the environment's view: it drives the unpacker and flash engine.
interface asmi_prog_ctrl_if;
    logic [7:0]  dseth_tdata;
    logic        dsethasmi_tvalid;
    logic        dsethasmi_tlast;
    logic [13:0] asmi_cnt;
    logic        dsethasmi_erase;
    logic        dsethasmi_erase_ack;
    logic        fl_req;
    logic [1:0]  fl_op;
    logic [23:0] fl_addr;
    logic        fl_ack;
    logic        fl_busy;
    logic        fl_dreq;
    logic [7:0]  fl_dout;
    logic        blk_done;
    logic        prog_done;
    logic        ovf_err;

    modport slave (
        input  dseth_tdata, dsethasmi_tvalid, dsethasmi_tlast, asmi_cnt,
               dsethasmi_erase, fl_ack, fl_busy, fl_dreq,
        output dsethasmi_erase_ack, fl_req, fl_op, fl_addr, fl_dout,
               blk_done, prog_done, ovf_err
    );

    modport master (
        output dseth_tdata, dsethasmi_tvalid, dsethasmi_tlast, asmi_cnt,
               dsethasmi_erase, fl_ack, fl_busy, fl_dreq,
        input  dsethasmi_erase_ack, fl_req, fl_op, fl_addr, fl_dout,
               blk_done, prog_done, ovf_err
    );
endinterface

// File: rtl/asmi_prog_ctrl.sv
// Purpose: sequences remote flash update traffic. Erases ERASE_SECTORS
//          sectors on request, captures 256-byte program blocks into a
//          ping-pong page buffer and issues page-program commands.
// Ports:
//   clk    - system clock (unpacker domain)
//   rst_n  - asynchronous active-low reset
//   bus    - asmi_prog_ctrl_if.slave (unpacker side + flash engine side)
//
// state    | meaning
// IDLE     | waiting for erase request or a full buffer bank
// ER_ISSUE | sector-erase command requested, waiting for fl_ack
// ER_WAIT  | sector erase running, waiting for fl_busy to fall
// ER_ACK   | all sectors erased, one-cycle erase ack
// PG_ISSUE | page-program command requested, waiting for fl_ack
// PG_WAIT  | page program running, serving fl_dreq from the read bank
// PG_DONE  | page finished, blk_done pulse, check for last block
module asmi_prog_ctrl #(
    parameter logic [23:0] BASE_ADDR     = 24'h100000,
    parameter int          ERASE_SECTORS = 16,
    parameter int          SECTOR_SHIFT  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    asmi_prog_ctrl_if.slave   bus
);
    localparam int IDX_W = $clog2(ERASE_SECTORS + 1);

    typedef enum logic [2:0] {
        IDLE, ER_ISSUE, ER_WAIT, ER_ACK, PG_ISSUE, PG_WAIT, PG_DONE
    } state_t;

    state_t r_state, w_next;

    logic [7:0]      r_mem [0:511];
    logic [1:0]      r_full;
    logic [1:0][8:0] r_len;
    logic            r_wbank, r_rbank, r_drop, r_sess, r_ovf;
    logic [7:0]      r_wptr, r_rptr, r_dout;
    logic [13:0]     r_cnt_tgt, r_blk_cnt;
    logic [23:0]     r_page;
    logic [IDX_W-1:0] r_idx;
    logic            r_erase_d, r_erase_pend, r_busy_d, r_prog_done;

    logic            w_busy_fall, w_erase_start, w_pg_free;
    logic            w_wr_ovf, w_blk_end, w_wr_en;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [23:0]     w_er_addr;
    logic [7:0]      w_rd_byte;
    logic            w_fl_req, w_erase_ack, w_blk_done;
    logic [1:0]      w_fl_op;
    logic [23:0]     w_fl_addr;

    assign w_busy_fall   = r_busy_d & ~bus.fl_busy;
    assign w_erase_start = (r_state == IDLE) & r_erase_pend;
    assign w_pg_free     = (r_state == PG_WAIT) & w_busy_fall;
    assign w_blk_end     = bus.dsethasmi_tlast | (r_wptr == 8'hFF);
    // Only the first byte of a block decides whether the whole block is dropped.
    assign w_wr_ovf      = bus.dsethasmi_tvalid & (r_wptr == 8'd0) & r_full[r_wbank];
    assign w_wr_en       = bus.dsethasmi_tvalid & ~w_wr_ovf & ~r_drop & ~w_erase_start;
    assign w_idx_nxt     = r_idx + 1'b1;
    assign w_er_addr     = BASE_ADDR + (24'(r_idx) << SECTOR_SHIFT);
    // Bytes past a short block's tlast read back as erased flash.
    assign w_rd_byte     = ({1'b0, r_rptr} < r_len[r_rbank]) ? r_mem[{r_rbank, r_rptr}] : 8'hFF;

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[{r_wbank, r_wptr}] <= bus.dseth_tdata;
    end

    // Buffer bookkeeping: write side runs independently of the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full    <= '0;
            r_len     <= '0;
            r_wbank   <= 1'b0;
            r_rbank   <= 1'b0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_drop    <= 1'b0;
            r_sess    <= 1'b0;
            r_ovf     <= 1'b0;
            r_cnt_tgt <= '0;
        end else if (w_erase_start) begin
            r_full  <= '0;
            r_wbank <= 1'b0;
            r_rbank <= 1'b0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_drop  <= 1'b0;
            r_sess  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_pg_free) begin
                r_full[r_rbank] <= 1'b0;
                r_rbank         <= ~r_rbank;
                r_rptr          <= '0;
            end else if (bus.fl_dreq) begin
                r_rptr <= r_rptr + 8'd1;
            end
            if (bus.dsethasmi_tvalid) begin
                if (!r_sess) begin
                    r_sess    <= 1'b1;
                    r_cnt_tgt <= bus.asmi_cnt;
                end
                if (w_wr_ovf)
                    r_ovf <= 1'b1;
                if (w_wr_ovf | r_drop) begin
                    r_drop <= ~w_blk_end;
                    r_wptr <= w_blk_end ? 8'd0 : r_wptr + 8'd1;
                end else if (w_blk_end) begin
                    r_full[r_wbank] <= 1'b1;
                    r_len[r_wbank]  <= {1'b0, r_wptr} + 9'd1;
                    r_wbank         <= ~r_wbank;
                    r_wptr          <= 8'd0;
                end else begin
                    r_wptr <= r_wptr + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_page       <= BASE_ADDR;
            r_blk_cnt    <= '0;
            r_prog_done  <= 1'b0;
            r_erase_d    <= 1'b0;
            r_erase_pend <= 1'b0;
            r_busy_d     <= 1'b0;
            r_dout       <= '0;
        end else begin
            r_state   <= w_next;
            r_erase_d <= bus.dsethasmi_erase;
            r_busy_d  <= bus.fl_busy;
            if (bus.fl_dreq)
                r_dout <= w_rd_byte;
            // A request arriving mid-page is remembered until IDLE can serve it.
            if (w_erase_start)
                r_erase_pend <= 1'b0;
            if (bus.dsethasmi_erase & ~r_erase_d)
                r_erase_pend <= 1'b1;
            if (w_erase_start) begin
                r_idx       <= '0;
                r_blk_cnt   <= '0;
                r_prog_done <= 1'b0;
            end
            if ((r_state == ER_WAIT) & w_busy_fall)
                r_idx <= w_idx_nxt;
            if (r_state == ER_ACK)
                r_page <= BASE_ADDR;
            if (w_pg_free) begin
                r_page    <= r_page + 24'd256;
                r_blk_cnt <= r_blk_cnt + 14'd1;
            end
            if ((r_state == PG_DONE) & (r_blk_cnt == r_cnt_tgt))
                r_prog_done <= 1'b1;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_fl_req    = 1'b0;
        w_fl_op     = 2'b00;
        w_fl_addr   = 24'h0;
        w_erase_ack = 1'b0;
        w_blk_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_erase_pend)
                    w_next = ER_ISSUE;
                else if (r_full[r_rbank])
                    w_next = PG_ISSUE;
            end
            ER_ISSUE: begin
                w_fl_req  = 1'b1;
                w_fl_op   = 2'b01;
                w_fl_addr = w_er_addr;
                if (bus.fl_ack)
                    w_next = ER_WAIT;
            end
            ER_WAIT: begin
                w_fl_op   = 2'b01;
                w_fl_addr = w_er_addr;
                if (w_busy_fall)
                    w_next = (w_idx_nxt == IDX_W'(ERASE_SECTORS)) ? ER_ACK : ER_ISSUE;
            end
            ER_ACK: begin
                w_erase_ack = 1'b1;
                w_next      = IDLE;
            end
            PG_ISSUE: begin
                w_fl_req  = 1'b1;
                w_fl_op   = 2'b10;
                w_fl_addr = r_page;
                if (bus.fl_ack)
                    w_next = PG_WAIT;
            end
            PG_WAIT: begin
                w_fl_op   = 2'b10;
                w_fl_addr = r_page;
                if (w_busy_fall)
                    w_next = PG_DONE;
            end
            PG_DONE: begin
                w_blk_done = 1'b1;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign bus.fl_req              = w_fl_req;
    assign bus.fl_op               = w_fl_op;
    assign bus.fl_addr             = w_fl_addr;
    assign bus.dsethasmi_erase_ack = w_erase_ack;
    assign bus.blk_done            = w_blk_done;
    assign bus.fl_dout             = r_dout;
    assign bus.prog_done           = r_prog_done;
    assign bus.ovf_err             = r_ovf;
endmodule

// File: tb/tb_asmi_prog_ctrl.sv
module tb_asmi_prog_ctrl;
    logic clk;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   busy_cycles = 10;

    asmi_prog_ctrl_if bus_if ();

    asmi_prog_ctrl #(
        .BASE_ADDR    (24'h100000),
        .ERASE_SECTORS(2),
        .SECTOR_SHIFT (16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // command log and captured page data from the engine model
    logic [1:0]  op_log   [0:63];
    logic [23:0] addr_log [0:63];
    int          cyc_log  [0:63];
    int          n_ops = 0;
    logic [7:0]  pg_mem  [0:15][0:255];
    logic [23:0] pg_addr [0:15];
    int          pg_n = 0;
    int          fall_cyc = 0;

    int tb_ack = 0;
    int ack_cyc = 0;
    int tb_blk = 0;
    int blk_last_cyc = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_if.dsethasmi_erase_ack) begin
                tb_ack  = tb_ack + 1;
                ack_cyc = cyc;
            end
            if (bus_if.blk_done) begin
                tb_blk       = tb_blk + 1;
                blk_last_cyc = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // flash engine model: ack, busy, pull 256 bytes for a program, abort on reset
    task automatic serve();
        logic [1:0]  op;
        logic [23:0] addr;
        logic [7:0]  buf_b [0:255];
        bit          aborted;
        op = bus_if.fl_op;
        addr = bus_if.fl_addr;
        aborted = 1'b0;
        if (n_ops < 64) begin
            op_log[n_ops] = op;
            addr_log[n_ops] = addr;
            cyc_log[n_ops] = cyc;
            n_ops++;
        end
        bus_if.fl_ack = 1'b1;
        @(posedge clk); #1;
        bus_if.fl_ack = 1'b0;
        bus_if.fl_busy = 1'b1;
        if (op == 2'b10) begin
            for (int k = 0; k < 256; k++) begin
                if (!rst_n) begin
                    aborted = 1'b1;
                    break;
                end
                bus_if.fl_dreq = 1'b1;
                @(posedge clk); #1;
                buf_b[k] = bus_if.fl_dout;
            end
            bus_if.fl_dreq = 1'b0;
        end
        for (int k = 0; k < busy_cycles; k++) begin
            if (!rst_n) begin
                aborted = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        bus_if.fl_busy = 1'b0;
        fall_cyc = cyc;
        if (op == 2'b10 && !aborted && rst_n && pg_n < 16) begin
            for (int k = 0; k < 256; k++) pg_mem[pg_n][k] = buf_b[k];
            pg_addr[pg_n] = addr;
            pg_n++;
        end
    endtask

    initial begin
        bus_if.fl_ack = 1'b0;
        bus_if.fl_busy = 1'b0;
        bus_if.fl_dreq = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst_n && bus_if.fl_req) serve();
        end
    end

    task automatic send_block(input int n, input logic [7:0] seed);
        for (int i = 0; i < n; i++) begin
            bus_if.dseth_tdata = 8'(i) + seed;
            bus_if.dsethasmi_tvalid = 1'b1;
            bus_if.dsethasmi_tlast = (i == n - 1);
            @(posedge clk); #1;
        end
        bus_if.dsethasmi_tvalid = 1'b0;
        bus_if.dsethasmi_tlast = 1'b0;
    endtask

    task automatic do_erase(input string tag);
        int a0 = tb_ack;
        int n = 0;
        bus_if.dsethasmi_erase = 1'b1;
        while (tb_ack == a0 && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        bus_if.dsethasmi_erase = 1'b0;
        chk(tag, 32'(tb_ack > a0), 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_blk(input int target, input string tag);
        int n = 0;
        while (tb_blk < target && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, 32'(tb_blk >= target), 1);
    endtask

    task automatic wait_ops(input int target, input string tag);
        int n = 0;
        while (n_ops < target && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, 32'(n_ops >= target), 1);
    endtask

    task automatic chk_page(input string tag, input int p, input logic [23:0] addr,
                            input logic [7:0] seed, input int len);
        int bad = 0;
        logic [7:0] exp;
        for (int k = 0; k < 256; k++) begin
            exp = (k < len) ? 8'(k) + seed : 8'hFF;
            if (pg_mem[p][k] !== exp) bad++;
        end
        chk({tag, "_addr"}, 32'(pg_addr[p]), 32'(addr));
        chk({tag, "_data"}, bad, 0);
    endtask

    task automatic chk_op(input string tag, input int i, input logic [1:0] op, input logic [23:0] addr);
        chk({tag, "_op"}, 32'(op_log[i]), 32'(op));
        chk({tag, "_addr"}, 32'(addr_log[i]), 32'(addr));
    endtask

    int b0, p0, k0;

    initial begin
        rst_n = 1'b0;
        bus_if.dseth_tdata = 8'h0;
        bus_if.dsethasmi_tvalid = 1'b0;
        bus_if.dsethasmi_tlast = 1'b0;
        bus_if.asmi_cnt = 14'd0;
        bus_if.dsethasmi_erase = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fl_req", 32'(bus_if.fl_req), 0);
        chk("rst_fl_op", 32'(bus_if.fl_op), 0);
        chk("rst_fl_addr", 32'(bus_if.fl_addr), 0);
        chk("rst_erase_ack", 32'(bus_if.dsethasmi_erase_ack), 0);
        chk("rst_blk_done", 32'(bus_if.blk_done), 0);
        chk("rst_prog_done", 32'(bus_if.prog_done), 0);
        chk("rst_ovf", 32'(bus_if.ovf_err), 0);
        chk("rst_dout", 32'(bus_if.fl_dout), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: erase of two sectors
        do_erase("t1_erase");
        chk_op("t1_sec0", 0, 2'b01, 24'h100000);
        chk_op("t1_sec1", 1, 2'b01, 24'h110000);
        chk("t1_ack_cnt", tb_ack, 1);
        chk("t1_ack_lat", ack_cyc - fall_cyc, 1);

        // 2: two full blocks, asmi_cnt = 2
        bus_if.asmi_cnt = 14'd2;
        b0 = n_ops; p0 = pg_n; k0 = tb_blk;
        send_block(256, 8'h00);
        send_block(256, 8'h00);
        wait_blk(k0 + 1, "t2_blk1");
        chk("t2_pd_early", 32'(bus_if.prog_done), 0);
        wait_blk(k0 + 2, "t2_blk2");
        repeat (2) @(posedge clk);
        #1;
        chk_op("t2_pg0", b0, 2'b10, 24'h100000);
        chk_op("t2_pg1", b0 + 1, 2'b10, 24'h100100);
        chk_page("t2_p0", p0, 24'h100000, 8'h00, 256);
        chk_page("t2_p1", p0 + 1, 24'h100100, 8'h00, 256);
        chk("t2_prog_done", 32'(bus_if.prog_done), 1);

        // 3: overflow while engine is slow
        do_erase("t3_erase");
        bus_if.asmi_cnt = 14'd5;
        busy_cycles = 2000;
        b0 = n_ops; p0 = pg_n; k0 = tb_blk;
        send_block(256, 8'h10);
        send_block(256, 8'h20);
        chk("t3_ovf_pre", 32'(bus_if.ovf_err), 0);
        send_block(256, 8'h30);
        chk("t3_ovf", 32'(bus_if.ovf_err), 1);
        wait_blk(k0 + 2, "t3_blks");
        repeat (50) @(posedge clk);
        #1;
        chk("t3_nops", n_ops - b0, 2);
        chk_page("t3_p0", p0, 24'h100000, 8'h10, 256);
        chk_page("t3_p1", p0 + 1, 24'h100100, 8'h20, 256);
        chk("t3_ovf_sticky", 32'(bus_if.ovf_err), 1);
        busy_cycles = 10;

        // 4: short block padded with 0xFF, next block in the other bank
        do_erase("t4_erase");
        chk("t4_ovf_clr", 32'(bus_if.ovf_err), 0);
        chk("t4_pd_clr", 32'(bus_if.prog_done), 0);
        bus_if.asmi_cnt = 14'd2;
        b0 = n_ops; p0 = pg_n; k0 = tb_blk;
        send_block(100, 8'h40);
        send_block(256, 8'h50);
        wait_blk(k0 + 2, "t4_blks");
        repeat (2) @(posedge clk);
        #1;
        chk_page("t4_p0", p0, 24'h100000, 8'h40, 100);
        chk_page("t4_p1", p0 + 1, 24'h100100, 8'h50, 256);
        chk("t4_prog_done", 32'(bus_if.prog_done), 1);

        // 5: erase request while a page is programming
        do_erase("t5_pre_erase");
        busy_cycles = 300;
        bus_if.asmi_cnt = 14'd3;
        b0 = n_ops; p0 = pg_n; k0 = tb_blk;
        send_block(256, 8'h60);
        wait_ops(b0 + 1, "t5_pg_start");
        repeat (20) @(posedge clk);
        #1;
        do_erase("t5_erase");
        chk_op("t5_pg", b0, 2'b10, 24'h100000);
        chk_op("t5_er0", b0 + 1, 2'b01, 24'h100000);
        chk_op("t5_er1", b0 + 2, 2'b01, 24'h110000);
        chk("t5_blk", tb_blk - k0, 1);
        chk("t5_order", 32'(blk_last_cyc < cyc_log[b0 + 1]), 1);
        chk_page("t5_p0", p0, 24'h100000, 8'h60, 256);

        // 6: reset during page program
        b0 = n_ops;
        send_block(256, 8'h70);
        wait_ops(b0 + 1, "t6_pg_start");
        repeat (20) @(posedge clk);
        #1;
        chk("t6_op_busy", 32'(bus_if.fl_op), 2);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("t6_rst_req", 32'(bus_if.fl_req), 0);
        chk("t6_rst_op", 32'(bus_if.fl_op), 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        chk("t6_idle_ops", n_ops - b0, 1);
        chk("t6_idle_req", 32'(bus_if.fl_req), 0);
        busy_cycles = 10;
        bus_if.asmi_cnt = 14'd1;
        b0 = n_ops; p0 = pg_n; k0 = tb_blk;
        send_block(256, 8'h80);
        wait_blk(k0 + 1, "t6_blk");
        repeat (2) @(posedge clk);
        #1;
        chk_op("t6_pg", b0, 2'b10, 24'h100000);
        chk_page("t6_p0", p0, 24'h100000, 8'h80, 256);
        chk("t6_prog_done", 32'(bus_if.prog_done), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
